pla_sweep_checker: RTL and testbench

- Stimulus and response end of the synthesized PLA benchmark netlists: drives the N_IN-bit input vector of a single-output combinational function and samples its y0.
- Exhaustively enumerates all 2^N_IN input vectors in ascending binary order.
- Accumulates on-set size, a serial LFSR signature and the first on-set minterm.
- Used on-chip or in emulation to prove that optimized and original netlists are equivalent, by comparing count and signature.

---
 rtl/pla_sweep_pkg.sv | 24 ++
 rtl/pla_sig_lfsr.sv | 38 +++
 rtl/pla_sweep_checker.sv | 126 ++++++++++++
 tb/tb_pla_sweep_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pla_sweep_pkg.sv
// Shared types and helpers for the PLA exhaustive sweep checker and its models.
// sig_step is the single definition of the serial Galois signature update.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam int          MAX_SIG_W    = 32;

  // One Galois step on the low w bits; higher bits of the result are cleared.
  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic b,
                                           input logic [31:0] poly, input int w);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = (w >= MAX_SIG_W) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    nxt  = {sig[30:0], 1'b0} ^ ((sig[w-1] ^ b) ? poly : 32'd0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/pla_sig_lfsr.sv
// Serial-input Galois signature register: init loads all ones, shift folds in one bit.
module pla_sig_lfsr
  import pla_sweep_pkg::*;
#(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             shift_en,
  input  logic             bit_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = '1;
    end else if (shift_en) begin
      sig_d = SIG_W'(sig_step(32'(sig_q), bit_i, 32'(POLY), SIG_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pla_sweep_checker.sv
// Exhaustive ascending sweep of an N_IN-input single-output function, accumulating
// on-set size, a serial signature of y_i and the lowest on-set minterm.
module pla_sweep_checker
  import pla_sweep_pkg::*;
#(
  parameter int          N_IN   = 15,
  parameter int          SETTLE = 0,
  parameter int          SIG_W  = 32,
  parameter logic [31:0] POLY   = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_o,
  output logic              vec_valid_o,
  input  logic              y_i,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     onset_count,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN-1:0]   first_on,
  output logic              first_on_valid
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int OC_W  = N_IN + 1;

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OC_W-1:0] onset_q, onset_d;
  logic [N_IN-1:0] first_on_q, first_on_d;
  logic            fov_q, fov_d;
  logic            sig_init;
  logic            sig_shift;
  logic            sample;

  // y_i is only meaningful on the last cycle a vector is held.
  assign sample = (cnt_q == CNT_W'(SETTLE));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    onset_d    = onset_q;
    first_on_d = first_on_q;
    fov_d      = fov_q;
    sig_init   = 1'b0;
    sig_shift  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          cnt_d      = '0;
          onset_d    = '0;
          first_on_d = '0;
          fov_d      = 1'b0;
          sig_init   = 1'b1;
        end
      end
      RUN: begin
        // abort wins over a coincident sample, so that sample is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (sample) begin
          onset_d   = onset_q + OC_W'(y_i);
          sig_shift = 1'b1;
          if (y_i && !fov_q) begin
            first_on_d = vec_q;
            fov_d      = 1'b1;
          end
          cnt_d = '0;
          if (vec_q == '1) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      onset_q    <= '0;
      first_on_q <= '0;
      fov_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      onset_q    <= onset_d;
      first_on_q <= first_on_d;
      fov_q      <= fov_d;
    end
  end

  pla_sig_lfsr #(
    .SIG_W (SIG_W),
    .POLY  (POLY[SIG_W-1:0])
  ) u_sig (
    .clk      (clk),
    .rst      (rst),
    .init     (sig_init),
    .shift_en (sig_shift),
    .bit_i    (y_i),
    .sig_o    (signature)
  );

  assign vec_o          = vec_q;
  assign busy           = (state_q == RUN);
  assign vec_valid_o    = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign onset_count    = onset_q;
  assign first_on       = first_on_q;
  assign first_on_valid = fov_q;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Bench for pla_sweep_checker: two instances (8-input same-cycle, 2-input with settle)
// driven from truth tables and checked against a vector-by-vector reference model.
module tb_pla_sweep_checker;
  import pla_sweep_pkg::*;

  localparam int NA = 8;
  localparam int VA = 1 << NA;
  localparam int NB = 2;
  localparam int SB = 2;
  localparam int VB = 1 << NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, abort_a = 1'b0;
  logic [NA-1:0] vec_a, fo_a;
  logic          vv_a, y_a, busy_a, done_a, fov_a;
  logic [NA:0]   cnt_a;
  logic [31:0]   sig_a;
  logic [VA-1:0] tt_a = '0;

  logic          start_b = 1'b0, abort_b = 1'b0;
  logic [NB-1:0] vec_b, fo_b;
  logic          vv_b, y_b, busy_b, done_b, fov_b;
  logic [NB:0]   cnt_b;
  logic [7:0]    sig_b;
  logic [VB-1:0] tt_b = '0;

  assign y_a = tt_a[vec_a];
  assign y_b = tt_b[vec_b];

  pla_sweep_checker #(.N_IN(NA), .SETTLE(0), .SIG_W(32), .POLY(DEFAULT_POLY)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .vec_o(vec_a),
    .vec_valid_o(vv_a), .y_i(y_a), .busy(busy_a), .done(done_a), .onset_count(cnt_a),
    .signature(sig_a), .first_on(fo_a), .first_on_valid(fov_a));

  pla_sweep_checker #(.N_IN(NB), .SETTLE(SB), .SIG_W(8), .POLY(32'h07)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .vec_o(vec_b),
    .vec_valid_o(vv_b), .y_i(y_b), .busy(busy_b), .done(done_b), .onset_count(cnt_b),
    .signature(sig_b), .first_on(fo_b), .first_on_valid(fov_b));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results after the first `upto` vectors of tt_a have been sampled in order.
  task automatic model_a(input int upto, output logic [NA:0] e_cnt, output logic [31:0] e_sig,
                         output logic [NA-1:0] e_fo, output logic e_fov);
    e_cnt = '0; e_sig = 32'hFFFF_FFFF; e_fo = '0; e_fov = 1'b0;
    for (int v = 0; v < upto; v++) begin
      if (tt_a[v]) begin
        if (!e_fov) begin e_fo = NA'(v); e_fov = 1'b1; end
        e_cnt++;
      end
      e_sig = sig_step(e_sig, tt_a[v], DEFAULT_POLY, 32);
    end
  endtask

  task automatic check_results_a(input string tag, input int upto);
    logic [NA:0] e_cnt; logic [31:0] e_sig; logic [NA-1:0] e_fo; logic e_fov;
    model_a(upto, e_cnt, e_sig, e_fo, e_fov);
    check_eq({tag, "/onset"}, cnt_a, e_cnt);
    check_eq({tag, "/sig"}, sig_a, e_sig);
    check_eq({tag, "/first_on"}, fo_a, e_fo);
    check_eq({tag, "/first_on_valid"}, fov_a, e_fov);
  endtask

  // mode: 0 full sweep, 1 abort at stop_at, 2 reset at stop_at.
  task automatic sweep_a(input string tag, input bit hold, input int stop_at, input int mode,
                         input bit abort_with_start);
    int cyc;
    @(negedge clk);
    start_a = 1'b1; abort_a = abort_with_start;
    @(posedge clk); #1;
    abort_a = 1'b0;
    if (!hold) start_a = 1'b0;
    @(negedge clk);
    check_eq({tag, "/enter_done"}, done_a, 0);
    check_eq({tag, "/enter_vec"}, vec_a, 0);
    check_eq({tag, "/enter_valid"}, vv_a, 1);
    cyc = 1;
    if (mode != 0) begin
      for (int i = 0; i < 2 * VA && vec_a != NA'(stop_at); i++) begin
        @(negedge clk); cyc++;
      end
      check_eq({tag, "/reach"}, vec_a, stop_at);
      if (mode == 1) abort_a = 1'b1; else rst = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0; rst = 1'b0; start_a = 1'b0;
      @(negedge clk);
      check_eq({tag, "/busy"}, busy_a, 0);
      check_eq({tag, "/done"}, done_a, 0);
      check_eq({tag, "/valid"}, vv_a, 0);
      if (mode == 1) begin
        check_eq({tag, "/vec"}, vec_a, stop_at);
        check_results_a(tag, stop_at);
      end else begin
        check_eq({tag, "/vec"}, vec_a, 0);
        check_eq({tag, "/onset"}, cnt_a, 0);
        check_eq({tag, "/sig"}, sig_a, 0);
        check_eq({tag, "/first_on"}, fo_a, 0);
        check_eq({tag, "/first_on_valid"}, fov_a, 0);
      end
      return;
    end
    for (int i = 0; i < 2 * VA && !done_a; i++) begin
      @(negedge clk);
      if (busy_a) cyc++;
    end
    start_a = 1'b0;
    check_eq({tag, "/done"}, done_a, 1);
    check_eq({tag, "/cycles"}, cyc, VA);
    check_eq({tag, "/busy"}, busy_a, 0);
    check_eq({tag, "/valid"}, vv_a, 0);
    check_eq({tag, "/vec_last"}, vec_a, VA - 1);
    check_results_a(tag, VA);
  endtask

  task automatic sweep_b(input string tag);
    int cyc;
    logic [NB:0] e_cnt; logic [31:0] e_sig; logic [NB-1:0] e_fo; logic e_fov;
    e_cnt = '0; e_sig = 32'hFF; e_fo = '0; e_fov = 1'b0;
    for (int v = 0; v < VB; v++) begin
      if (tt_b[v]) begin
        if (!e_fov) begin e_fo = NB'(v); e_fov = 1'b1; end
        e_cnt++;
      end
      e_sig = sig_step(e_sig, tt_b[v], 32'h07, 8);
    end
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8 * VB * (SB + 1) && !done_b; i++) begin
      @(negedge clk);
      if (busy_b) cyc++;
    end
    check_eq({tag, "/done"}, done_b, 1);
    check_eq({tag, "/cycles"}, cyc, VB * (SB + 1));
    check_eq({tag, "/vec_last"}, vec_b, VB - 1);
    check_eq({tag, "/onset"}, cnt_b, e_cnt);
    check_eq({tag, "/sig"}, sig_b, e_sig);
    check_eq({tag, "/first_on"}, fo_b, e_fo);
    check_eq({tag, "/first_on_valid"}, fov_b, e_fov);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset/vec", vec_a, 0);
    check_eq("reset/valid", vv_a, 0);
    check_eq("reset/busy", busy_a, 0);
    check_eq("reset/done", done_a, 0);
    check_eq("reset/onset", cnt_a, 0);
    check_eq("reset/sig", sig_a, 0);
    check_eq("reset/first_on", {fov_a, fo_a}, 0);
    check_eq("reset/b_all", {vv_b, busy_b, done_b, cnt_b, sig_b, fov_b, fo_b, vec_b}, 0);
    rst = 1'b0;

    tt_a = '0;
    sweep_a("zero", 0, -1, 0, 0);

    for (int v = 0; v < VA; v++) tt_a[v] = v[0];
    sweep_a("odd", 0, -1, 0, 0);
    check_eq("odd/onset_const", cnt_a, VA / 2);
    check_eq("odd/first_on_const", fo_a, 1);

    tt_a = '0; tt_a[VA-1] = 1'b1;
    sweep_a("top", 0, -1, 0, 0);
    check_eq("top/onset_const", cnt_a, 1);
    check_eq("top/first_on_const", fo_a, VA - 1);
    repeat (3) @(negedge clk);
    check_eq("top/vec_hold", vec_a, VA - 1);
    check_eq("top/done_hold", done_a, 1);

    // abort in DONE is ignored
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    check_eq("done_abort/done", done_a, 1);

    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < VA; v++) tt_a[v] = ($urandom_range(0, 3) < k);
      sweep_a($sformatf("rand%0d", k), 0, -1, 0, 0);
    end

    for (int v = 0; v < VA; v++) tt_a[v] = $urandom_range(0, 1);
    sweep_a("abort", 0, 100, 1, 0);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    check_eq("idle_abort/busy", busy_a, 0);
    sweep_a("after_abort", 0, -1, 0, 0);
    sweep_a("rst", 0, 100, 2, 0);
    sweep_a("after_rst", 0, -1, 0, 0);
    sweep_a("hold_start", 1, -1, 0, 0);
    sweep_a("restart", 0, -1, 0, 0);
    sweep_a("start_abort", 0, -1, 0, 1);

    tt_b = 4'b0000;
    sweep_b("b_zero");
    check_eq("b_zero/sig_const", sig_b, 8'hDD);
    tt_b = 4'b1111;
    sweep_b("b_one");
    check_eq("b_one/onset_const", cnt_b, 4);
    tt_b = 4'b1010;
    sweep_b("b_odd");
    for (int k = 0; k < 3; k++) begin
      tt_b = 4'($urandom_range(0, 15));
      sweep_b($sformatf("b_rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
